// File: rtl/inertial_integrator_cal.sv
// Pitch integrator with gyro/accelerometer bang-bang fusion and run-time gyro-offset calibration.
// Define INTEG_SAT_EN to saturate the integrator instead of letting it wrap.
module inertial_integrator_cal #(
    parameter int               RT_W          = 16,
    parameter int               INT_FRAC      = 11,
    parameter logic [RT_W-1:0]  DEF_RT_OFFSET = 16'h03C2,
    parameter logic [RT_W-1:0]  AZ_OFFSET     = 16'hFE80,
    parameter int               ACC_SCALE     = 327,
    parameter int               FUSION_GAIN   = 512,
    parameter int               CAL_LOG2      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vld,
    input  logic            cal_start,
    input  logic [RT_W-1:0] ptch_rt,
    input  logic [RT_W-1:0] AZ,
    output logic [RT_W-1:0] ptch,
    output logic            ptch_vld,
    output logic            cal_busy,
    output logic            cal_done
);

    localparam int INT_W = RT_W + INT_FRAC;
    localparam int ACC_W = RT_W + CAL_LOG2;

    localparam logic signed [RT_W:0]    ACC_SCALE_S = (RT_W+1)'(ACC_SCALE);
    localparam logic signed [INT_W-1:0] FUSION_POS  = INT_W'(FUSION_GAIN);
    localparam logic signed [INT_W-1:0] FUSION_NEG  = -FUSION_POS;

    typedef enum logic {RUN, CAL} state_t;

    state_t                    state, state_nxt;
    logic signed [INT_W-1:0]   ptch_int, integ_nxt;
    logic signed [RT_W-1:0]    rt_offset;
    logic signed [ACC_W-1:0]   cal_acc, cal_sum;
    logic        [CAL_LOG2-1:0] cal_cnt;
    logic                      cal_last;

    logic signed [RT_W:0]      rt_comp, az_comp;
    logic signed [2*RT_W+1:0]  az_prod;
    logic signed [RT_W-1:0]    ptch_acc;
    logic signed [INT_W-1:0]   fusion;

    assign ptch     = ptch_int[INT_W-1:INT_FRAC];
    assign cal_busy = (state == CAL);

    assign rt_comp  = $signed({ptch_rt[RT_W-1], ptch_rt}) - $signed({rt_offset[RT_W-1], rt_offset});
    assign az_comp  = $signed({AZ[RT_W-1], AZ}) - $signed({AZ_OFFSET[RT_W-1], AZ_OFFSET});
    assign az_prod  = az_comp * ACC_SCALE_S;
    assign ptch_acc = RT_W'(az_prod >>> 13);
    assign fusion   = (ptch_acc > $signed(ptch)) ? FUSION_POS : FUSION_NEG;
    assign cal_sum  = cal_acc + ACC_W'($signed(ptch_rt));

`ifdef INTEG_SAT_EN
    localparam logic signed [INT_W+1:0] SAT_MAX = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W+1:0] SAT_MIN = {3'b111, {(INT_W-1){1'b0}}};
    logic signed [INT_W+1:0] sum_wide;

    // Two guard bits keep the unclamped sum exact before it is pinned to the integrator range.
    always_comb begin
        sum_wide = {{2{ptch_int[INT_W-1]}}, ptch_int}
                 - {{(INT_W+1-RT_W){rt_comp[RT_W]}}, rt_comp}
                 + {{2{fusion[INT_W-1]}}, fusion};
        if (sum_wide > SAT_MAX)
            integ_nxt = SAT_MAX[INT_W-1:0];
        else if (sum_wide < SAT_MIN)
            integ_nxt = SAT_MIN[INT_W-1:0];
        else
            integ_nxt = sum_wide[INT_W-1:0];
    end
`else
    assign integ_nxt = ptch_int - {{(INT_W-RT_W-1){rt_comp[RT_W]}}, rt_comp} + fusion;
`endif

    always_comb begin
        state_nxt = state;
        cal_last  = 1'b0;
        case (state)
            RUN: if (cal_start) state_nxt = CAL;
            CAL: begin
                if (vld && (cal_cnt == {CAL_LOG2{1'b1}})) begin
                    cal_last  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ptch_int  <= '0;
            rt_offset <= DEF_RT_OFFSET;
            cal_acc   <= '0;
            cal_cnt   <= '0;
            ptch_vld  <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptch_vld <= vld && (state == RUN);
            cal_done <= cal_last;
            if (state == RUN) begin
                if (vld)
                    ptch_int <= integ_nxt;
                if (cal_start) begin
                    cal_acc <= '0;
                    cal_cnt <= '0;
                end
            end else begin
                // The integrator is meaningless while the offset is being re-measured.
                ptch_int <= '0;
                if (vld) begin
                    cal_acc <= cal_sum;
                    cal_cnt <= cal_cnt + 1'b1;
                    if (cal_last)
                        rt_offset <= RT_W'(cal_sum >>> CAL_LOG2);
                end
            end
        end
    end

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Directed, table-driven bench for inertial_integrator_cal (built with CAL_LOG2=4).
module tb_inertial_integrator_cal;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        cal_start = 1'b0;
    logic [15:0] ptch_rt = 16'h0000;
    logic [15:0] AZ = 16'hFE80;
    logic [15:0] ptch;
    logic        ptch_vld;
    logic        cal_busy;
    logic        cal_done;

    int assert_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [15:0] rt;
        logic [15:0] az;
        logic        v;
        logic [15:0] exp_ptch;
        logic        exp_pvld;
    } vec_t;

    vec_t vecs[13];

    inertial_integrator_cal #(.CAL_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .cal_start(cal_start),
        .ptch_rt(ptch_rt), .AZ(AZ), .ptch(ptch), .ptch_vld(ptch_vld),
        .cal_busy(cal_busy), .cal_done(cal_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive at a falling edge; return at the next falling edge with the result registered.
    task automatic applyStimulus(input logic [15:0] rt, input logic [15:0] az, input logic v, input logic cs);
        ptch_rt   = rt;
        AZ        = az;
        vld       = v;
        cal_start = cs;
        @(negedge clk);
        vld       = 1'b0;
        cal_start = 1'b0;
    endtask

    task automatic checkAll(input string name, input logic [15:0] p, input logic pv, input logic cb, input logic cd);
        checkOutput({name, " ptch"}, {16'h0, ptch}, {16'h0, p});
        checkOutput({name, " ptch_vld"}, {31'h0, ptch_vld}, {31'h0, pv});
        checkOutput({name, " cal_busy"}, {31'h0, cal_busy}, {31'h0, cb});
        checkOutput({name, " cal_done"}, {31'h0, cal_done}, {31'h0, cd});
    endtask

    initial begin
        // Zero-rate dither then constant rate of -2048 counts per sample after offset removal.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{16'h03C2, 16'hFE80, 1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b1};
        vecs[8]  = '{16'h03C2, 16'hFE80, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{16'hFBC2, 16'hFE80, 1'b1, 16'h0000, 1'b1};
        vecs[10] = '{16'hFBC2, 16'hFE80, 1'b1, 16'h0001, 1'b1};
        vecs[11] = '{16'hFBC2, 16'hFE80, 1'b1, 16'h0002, 1'b1};
        vecs[12] = '{16'hFBC2, 16'hFE80, 1'b1, 16'h0003, 1'b1};

        #2;
        checkAll("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rt, vecs[i].az, vecs[i].v, 1'b0);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_ptch, vecs[i].exp_pvld, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-stream while ptch=3 and ptch_vld=1.
        #1 rst_n = 1'b0;
        #1 checkAll("async reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Calibration: 16 samples of 0x0100 give offset 0x0100.
        applyStimulus(16'h0100, 16'hFE80, 1'b0, 1'b1);
        checkOutput("cal entry busy", {31'h0, cal_busy}, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(16'h0100, 16'hFE80, 1'b1, 1'b0);
            if (i < 16)
                checkAll($sformatf("cal s%0d", i), 16'h0000, 1'b0, 1'b1, 1'b0);
            else
                checkAll("cal last", 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(16'h0100, 16'hFE80, 1'b0, 1'b0);
        checkOutput("cal_done one cycle", {31'h0, cal_done}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'h0100, 16'hFE80, 1'b1, 1'b0);
            checkOutput($sformatf("post-cal ptch%0d", i), {16'h0, ptch}, (i % 2 == 0) ? 32'hFFFF : 32'h0);
        end

        // A second cal_start mid-calibration must not restart the sample count.
        applyStimulus(16'h0100, 16'hFE80, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) applyStimulus(16'h0100, 16'hFE80, 1'b1, 1'b0);
        applyStimulus(16'h0100, 16'hFE80, 1'b0, 1'b1);
        for (int i = 9; i <= 16; i++) begin
            applyStimulus(16'h0100, 16'hFE80, 1'b1, 1'b0);
            if (i == 15) checkAll("recal s15", 16'h0000, 1'b0, 1'b1, 1'b0);
            if (i == 16) checkAll("recal s16", 16'h0000, 1'b0, 1'b0, 1'b1);
        end

        // Reset after 10 samples discards the partial calibration and restores 0x03C2.
        applyStimulus(16'h0000, 16'hFE80, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(16'h0000, 16'hFE80, 1'b1, 1'b0);
        checkOutput("partial cal busy", {31'h0, cal_busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1 checkAll("reset in cal", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h03C2, 16'hFE80, 1'b1, 1'b0);
            checkOutput($sformatf("default offset ptch%0d", i), {16'h0, ptch}, (i % 2 == 0) ? 32'hFFFF : 32'h0);
        end
        applyStimulus(16'h03C2, 16'hFE80, 1'b0, 1'b1);
        checkOutput("cal accepted after reset", {31'h0, cal_busy}, 32'h1);

        // Saturation: each sample adds 33218 net while ptch stays non-negative.
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 2100; i++) begin
            applyStimulus(16'h8000, 16'hFE80, 1'b1, 1'b0);
            if (i == 2020) checkOutput("sat n2020", {16'h0, ptch}, 32'h7FFB);
`ifdef INTEG_SAT_EN
            if (i == 2021) checkOutput("sat n2021", {16'h0, ptch}, 32'h7FFF);
`else
            if (i == 2021) checkOutput("wrap n2021", {16'h0, ptch}, 32'h800C);
`endif
        end
`ifdef INTEG_SAT_EN
        checkOutput("sat n2100", {16'h0, ptch}, 32'h7FFF);
`else
        checkOutput("wrap n2100", {16'h0, ptch}, 32'h8534);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
